conv_param: RTL and testbench

CONV_PARAM -- requirements
Module: conv_param

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_mac_lane.sv | 55 +++++
 rtl/conv_param.sv | 137 +++++++++++++
 tb/tb_conv_param.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM type and arithmetic helpers
// for the conv_param 1-D convolution engine
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    function automatic int acc_w(input int t, input int m);
        return 2 * t + $clog2(m);
    endfunction

    function automatic logic signed [127:0] sat_relu(
        input logic signed [127:0] v,
        input int                  t,
        input bit                  relu
    );
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        logic signed [127:0] r;
        hi = (128'sd1 <<< (t - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (t - 1));
        r  = v;
        if (v > hi) r = hi;
        if (v < lo) r = lo;
        if (relu && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one MAC lane with operand, product and
// accumulator registers plus saturating output
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int T    = 16,
    parameter int M    = 33,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                clr,
    input  logic signed [T-1:0] x,
    input  logic signed [T-1:0] f,
    output logic signed [T-1:0] y
);

    localparam int AW = acc_w(T, M);

    logic signed [T-1:0]   xa;
    logic signed [T-1:0]   fb;
    logic                  v1;
    logic                  v2;
    logic signed [2*T-1:0] prod;
    logic signed [AW-1:0]  acc;

    // operand read -> product register -> accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            xa   <= '0;
            fb   <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= rd;
            v2 <= v1;
            if (rd) begin
                xa <= x;
                fb <= f;
            end
            prod <= xa * fb;
            if (clr) begin
                acc <= '0;
            end else if (v2) begin
                acc <= acc + AW'(prod);
            end
        end
    end

    assign y = T'(sat_relu(128'(acc), T, RELU != 0));

endmodule

// File: rtl/conv_param.sv
// conv_param: valid/ready 1-D valid-mode convolution,
// P parallel MAC lanes, filter loaded once per reset
module conv_param
    import conv_pkg::*;
#(
    parameter int N    = 64,
    parameter int M    = 33,
    parameter int T    = 16,
    parameter int P    = 4,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    input  logic signed [T-1:0] s_data_in_f,
    input  logic                s_valid_f,
    output logic                s_ready_f,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);

    if (M < 2 || M > N) begin : g_bad_m
        $error("conv_param: M must satisfy 2 <= M <= N");
    end
    if ((N - M + 1) % P != 0) begin : g_bad_p
        $error("conv_param: (N-M+1) must be a multiple of P");
    end

    localparam int G   = (N - M + 1) / P;
    localparam int XW  = $clog2(N);
    localparam int XCW = $clog2(N + 1);
    localparam int FW  = $clog2(M);
    localparam int FCW = $clog2(M + 1);
    localparam int CW  = $clog2(M + 3);
    localparam int OW  = (P > 1) ? $clog2(P) : 1;

    state_t state;
    state_t state_nx;

    logic [XCW-1:0] xcnt;
    logic [FCW-1:0] fcnt;
    logic [CW-1:0]  cyc;
    logic [XW-1:0]  base;
    logic [OW-1:0]  oidx;
    logic [FW-1:0]  kf;

    logic signed [T-1:0] x_mem  [N];
    logic signed [T-1:0] f_mem  [M];
    logic signed [T-1:0] lane_y [P];

    logic x_fire, f_fire, y_fire;
    logic x_done, f_done;
    logic last_y, last_grp;
    logic rd, clr;

    assign s_ready_x = !reset && state == LOAD && xcnt != XCW'(N);
    assign s_ready_f = !reset && fcnt != FCW'(M);
    assign m_valid_y = !reset && state == OUTPUT;
    assign m_data_out_y = lane_y[oidx];

    assign x_fire = s_valid_x && s_ready_x;
    assign f_fire = s_valid_f && s_ready_f;
    assign y_fire = m_valid_y && m_ready_y;

    assign x_done = xcnt == XCW'(N) ||
                    (x_fire && xcnt == XCW'(N - 1));
    assign f_done = fcnt == FCW'(M) ||
                    (f_fire && fcnt == FCW'(M - 1));

    assign last_y   = y_fire && oidx == OW'(P - 1);
    assign last_grp = base == XW'((G - 1) * P);

    assign kf  = cyc[FW-1:0];
    assign rd  = state == COMPUTE && cyc < CW'(M);
    assign clr = state != COMPUTE && state_nx == COMPUTE;

    // next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (x_done && f_done) state_nx = COMPUTE;
            COMPUTE: if (cyc == CW'(M + 2)) state_nx = OUTPUT;
            OUTPUT:  if (last_y) state_nx = last_grp ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    // state, counters and group bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            xcnt  <= '0;
            fcnt  <= '0;
            cyc   <= '0;
            base  <= '0;
            oidx  <= '0;
        end else begin
            state <= state_nx;
            cyc   <= (state == COMPUTE) ? cyc + 1'b1 : '0;
            if (x_fire) xcnt <= xcnt + 1'b1;
            if (f_fire) fcnt <= fcnt + 1'b1;
            if (y_fire) oidx <= last_y ? '0 : oidx + 1'b1;
            if (last_y) begin
                base <= last_grp ? '0 : base + XW'(P);
                if (last_grp) xcnt <= '0;
            end
        end
    end

    // capture accepted x words and filter taps
    always_ff @(posedge clk) begin
        if (x_fire) x_mem[xcnt[XW-1:0]] <= s_data_in_x;
        if (f_fire) f_mem[fcnt[FW-1:0]] <= s_data_in_f;
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [XW-1:0] xi;
        assign xi = base + XW'(p) + XW'(kf);
        conv_mac_lane #(
            .T    (T),
            .M    (M),
            .RELU (RELU)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .rd    (rd),
            .clr   (clr),
            .x     (x_mem[xi]),
            .f     (f_mem[kf]),
            .y     (lane_y[p])
        );
    end

endmodule

// File: tb/tb_conv_param.sv
// tb_conv_param: scoreboard bench for conv_param with a
// small directed pair (RELU 0/1) and a random default instance
module tb_conv_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst_ab, ab_xv, ab_fv, ab_ry;
    logic [15:0] ab_x, ab_f;
    logic        rx_a, rf_a, v_a, rx_b, rf_b, v_b;
    logic [15:0] y_a, y_b;

    logic        rst_c, c_xv, c_fv, c_ry;
    logic [15:0] c_x, c_f, y_c;
    logic        rx_c, rf_c, v_c;

    int qa[$];
    int qb[$];
    int qc[$];
    int c_outs = 0;

    conv_param #(.N(8), .M(3), .T(16), .P(2), .RELU(0)) dut_a (
        .clk(clk), .reset(rst_ab),
        .s_data_in_x(ab_x), .s_valid_x(ab_xv), .s_ready_x(rx_a),
        .s_data_in_f(ab_f), .s_valid_f(ab_fv), .s_ready_f(rf_a),
        .m_data_out_y(y_a), .m_valid_y(v_a), .m_ready_y(ab_ry)
    );

    conv_param #(.N(8), .M(3), .T(16), .P(2), .RELU(1)) dut_b (
        .clk(clk), .reset(rst_ab),
        .s_data_in_x(ab_x), .s_valid_x(ab_xv), .s_ready_x(rx_b),
        .s_data_in_f(ab_f), .s_valid_f(ab_fv), .s_ready_f(rf_b),
        .m_data_out_y(y_b), .m_valid_y(v_b), .m_ready_y(ab_ry)
    );

    conv_param dut_c (
        .clk(clk), .reset(rst_c),
        .s_data_in_x(c_x), .s_valid_x(c_xv), .s_ready_x(rx_c),
        .s_data_in_f(c_f), .s_valid_f(c_fv), .s_ready_f(rf_c),
        .m_data_out_y(y_c), .m_valid_y(v_c), .m_ready_y(c_ry)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic int ref_y(input int xv[$], input int fv[$],
                                 input int i, input bit relu);
        longint s = 0;
        for (int k = 0; k < fv.size(); k++)
            s += longint'(xv[i + k]) * longint'(fv[k]);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (v_a && ab_ry) begin
            if (qa.size() == 0)
                check("a_extra_y", int'($signed(y_a)), 99999);
            else
                check("a_y", int'($signed(y_a)), qa.pop_front());
        end
        if (v_b && ab_ry) begin
            if (qb.size() == 0)
                check("b_extra_y", int'($signed(y_b)), 99999);
            else
                check("b_y", int'($signed(y_b)), qb.pop_front());
        end
    end

    logic        c_hold = 1'b0;
    logic [15:0] c_held = '0;
    always @(negedge clk) begin
        if (c_hold) begin
            check("c_stall_valid", int'(v_c), 1);
            check("c_stall_data", int'(y_c), int'(c_held));
        end
        c_hold = v_c && !c_ry;
        c_held = y_c;
        if (v_c && c_ry) begin
            c_outs++;
            if (qc.size() == 0)
                check("c_extra_y", int'($signed(y_c)), 99999);
            else
                check("c_y", int'($signed(y_c)), qc.pop_front());
        end
    end

    initial begin
        c_ry = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c_ry = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- directed pair ----------------
    task automatic ab_reset();
        rst_ab = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clk);
        check("rst_outs", int'({rx_a, rf_a, v_a}), 0);
        @(posedge clk);
        #1;
        rst_ab = 1'b0;
        @(negedge clk);
        check("post_rst_outs", int'({rx_a, rf_a, v_a}), 6);
        @(posedge clk);
        #1;
    endtask

    task automatic ab_send_x(input int d);
        int n = 0;
        ab_x = 16'(d);
        ab_xv = 1'b1;
        @(negedge clk);
        while (!rx_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ab_x_timeout", n, 0);
        @(posedge clk);
        #1;
        ab_xv = 1'b0;
    endtask

    task automatic ab_send_f(input int d);
        int n = 0;
        ab_f = 16'(d);
        ab_fv = 1'b1;
        @(negedge clk);
        while (!rf_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ab_f_timeout", n, 0);
        @(posedge clk);
        #1;
        ab_fv = 1'b0;
    endtask

    task automatic ab_vector(input int fv[$], input int xv[$],
                             input bit f_last, input bit drain);
        int n;
        for (int i = 0; i <= 5; i++) begin
            qa.push_back(ref_y(xv, fv, i, 1'b0));
            qb.push_back(ref_y(xv, fv, i, 1'b1));
        end
        if (!f_last) begin
            foreach (fv[k]) ab_send_f(fv[k]);
            foreach (xv[k]) ab_send_x(xv[k]);
        end else begin
            foreach (xv[k]) ab_send_x(xv[k]);
            foreach (fv[k]) ab_send_f(fv[k]);
            n = 0;
            @(negedge clk);
            while (!v_a && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("first_valid_latency", n, 3 + 3);
            @(posedge clk);
            #1;
        end
        if (drain) begin
            n = 0;
            while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 400) check("ab_drain_timeout", n, 0);
        end
    endtask

    task automatic run_ab();
        int seq[$], ones[$], neg[$], fmax[$], xmax[$], xmin[$];
        int n;
        for (int i = 1; i <= 8; i++) seq.push_back(i);
        for (int i = 0; i < 8; i++) xmax.push_back(32767);
        for (int i = 0; i < 8; i++) xmin.push_back(-32768);
        for (int k = 0; k < 3; k++) begin
            ones.push_back(1);
            neg.push_back(-1);
            fmax.push_back(32767);
        end
        ab_reset();
        ab_vector(ones, seq, 1'b0, 1'b1);
        ab_reset();
        ab_vector(fmax, xmax, 1'b0, 1'b1);
        ab_reset();
        ab_vector(fmax, xmin, 1'b0, 1'b1);
        ab_reset();
        ab_vector(neg, seq, 1'b1, 1'b1);
        ab_reset();
        ab_vector(ones, seq, 1'b0, 1'b0);
        n = 0;
        while (qa.size() != 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("grp1_wait_timeout", n, 0);
        ab_reset();
        ab_vector(ones, seq, 1'b0, 1'b1);
    endtask

    // ---------------- random default instance ----------------
    task automatic c_send_x(input int d);
        int n = 0;
        c_xv = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        c_x = 16'(d);
        c_xv = 1'b1;
        @(negedge clk);
        while (!rx_c && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("c_x_timeout", n, 0);
        @(posedge clk);
        #1;
        c_xv = 1'b0;
    endtask

    task automatic c_send_f(input int d);
        int n = 0;
        c_fv = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
        end
        c_f = 16'(d);
        c_fv = 1'b1;
        @(negedge clk);
        while (!rf_c && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("c_f_timeout", n, 0);
        @(posedge clk);
        #1;
        c_fv = 1'b0;
    endtask

    task automatic c_load_x(input int xv[$]);
        foreach (xv[k]) c_send_x(xv[k]);
    endtask

    task automatic c_load_f(input int fv[$]);
        foreach (fv[k]) c_send_f(fv[k]);
    endtask

    task automatic run_c();
        int fv[$], xv[$];
        int n;
        bit big;
        rst_c = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_c = 1'b0;
        for (int k = 0; k < 33; k++)
            fv.push_back(int'($urandom_range(0, 30)) - 15);
        for (int v = 0; v < 156; v++) begin
            xv.delete();
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++)
                xv.push_back(big ? int'($urandom_range(0, 65535)) - 32768
                                 : int'($urandom_range(0, 126)) - 63);
            for (int i = 0; i <= 31; i++)
                qc.push_back(ref_y(xv, fv, i, 1'b0));
            if (v == 0) begin
                fork
                    c_load_f(fv);
                    c_load_x(xv);
                join
            end else begin
                c_load_x(xv);
            end
        end
        n = 0;
        while (qc.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) check("c_drain_timeout", n, 0);
    endtask

    initial begin
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        ab_x = '0; ab_f = '0; ab_xv = 1'b0; ab_fv = 1'b0; ab_ry = 1'b1;
        c_x = '0;  c_f = '0;  c_xv = 1'b0;  c_fv = 1'b0;
        @(posedge clk);
        #1;
        fork
            run_ab();
            run_c();
        join
        repeat (4) @(posedge clk);
        check("c_output_count", c_outs, 4992);
        check("ab_left", qa.size() + qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
